// File: rtl/_load_store_unit_if.sv
// Request, data-memory and writeback signals of the load/store unit.
// slave is the unit's side; master is the register-file/memory side.
interface _load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic [2:0]  req_rd;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;

  logic        busy;
  logic        err;
  logic [1:0]  err_code;
  logic        err_clr;

  modport slave (
    input  req_valid, req_we, req_byte, req_rd, req_addr, req_wdata,
    input  mem_ack, mem_rdata, err_clr,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output wb_valid, wb_rd, wb_data, busy, err, err_code
  );

  modport master (
    output req_valid, req_we, req_byte, req_rd, req_addr, req_wdata,
    output mem_ack, mem_rdata, err_clr,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  wb_valid, wb_rd, wb_data, busy, err, err_code
  );
endinterface

// File: rtl/_load_store_unit.sv
// Data-memory access stage: one load/store per transaction over a req/ack
// memory handshake, with byte lanes, misalignment detection and a timeout.
module _load_store_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  _load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  lane;
  logic [2:0]  rd_q;
  logic        byte_q;
  logic        misaligned;
  logic [7:0]  rbyte;

  assign misaligned    = !bus.req_byte && (bus.req_addr[1:0] != 2'b00);
  assign rbyte         = 8'(bus.mem_rdata >> {lane, 3'b000});
  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      lane          <= '0;
      rd_q          <= '0;
      byte_q        <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.wb_valid  <= 1'b0;
      bus.wb_rd     <= '0;
      bus.wb_data   <= '0;
      bus.err       <= 1'b0;
      bus.err_code  <= '0;
    end else begin
      // Clear first so an error raised below in the same cycle takes precedence.
      if (bus.err_clr) begin
        bus.err      <= 1'b0;
        bus.err_code <= '0;
      end
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (misaligned) begin
              bus.err      <= 1'b1;
              bus.err_code <= 2'b01;
            end else begin
              state         <= ISSUE;
              cnt           <= '0;
              lane          <= bus.req_addr[1:0];
              rd_q          <= bus.req_rd;
              byte_q        <= bus.req_byte;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_we;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_wdata <= bus.req_byte ? {4{bus.req_wdata[7:0]}} : bus.req_wdata;
              bus.mem_be    <= bus.req_byte ? (4'b0001 << bus.req_addr[1:0]) : 4'hF;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (bus.mem_we) begin
              state <= IDLE;
            end else begin
              state        <= RESP;
              bus.wb_valid <= 1'b1;
              bus.wb_rd    <= rd_q;
              bus.wb_data  <= byte_q ? {24'h0, rbyte} : bus.mem_rdata;
            end
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state        <= IDLE;
            bus.mem_req  <= 1'b0;
            bus.err      <= 1'b1;
            bus.err_code <= 2'b10;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state        <= IDLE;
          bus.wb_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb__load_store_unit.sv
// Directed self-checking bench for _load_store_unit; inputs change and
// outputs are sampled on the falling clock edge.
module tb__load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  _load_store_unit_if bus();

  _load_store_unit #(.TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_rd    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.err_clr   = 1'b0;
  endtask

  task automatic present(input logic we, input logic byt, input logic [2:0] rd,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_byte  = byt;
    bus.req_rd    = rd;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.req_ready, bus.busy, bus.mem_req, bus.mem_we, bus.wb_valid, bus.err, bus.err_code} !== 8'b1000_0000) begin
      failed++;
      $display("FAIL reset_flags: got %b expected %b",
               {bus.req_ready, bus.busy, bus.mem_req, bus.mem_we, bus.wb_valid, bus.err, bus.err_code}, 8'b1000_0000);
    end
    tests++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
      failed++;
      $display("FAIL reset_mem_bus: got %h expected %h", {bus.mem_addr, bus.mem_wdata}, 64'h0);
    end
    tests++;
    if ({bus.mem_be, bus.wb_rd, bus.wb_data} !== 39'h0) begin
      failed++;
      $display("FAIL reset_wb: got %h expected %h", {bus.mem_be, bus.wb_rd, bus.wb_data}, 39'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.req_ready, bus.mem_req} !== 2'b10) begin
      failed++;
      $display("FAIL reset_release: got %b expected %b", {bus.req_ready, bus.mem_req}, 2'b10);
    end
  endtask

  task automatic test_word_load();
    present(1'b0, 1'b0, 3'd5, 32'h0000_0010, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    tests++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_we} !== {1'b1, 32'h10, 4'hF, 1'b0}) begin
      failed++;
      $display("FAIL wload_issue: got %h expected %h",
               {bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_we}, {1'b1, 32'h10, 4'hF, 1'b0});
    end
    tests++;
    if ({bus.req_ready, bus.busy} !== 2'b01) begin
      failed++;
      $display("FAIL wload_busy: got %b expected %b", {bus.req_ready, bus.busy}, 2'b01);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_be, bus.wb_valid} !== {1'b1, 32'h10, 4'hF, 1'b0}) begin
      failed++;
      $display("FAIL wload_hold: got %h expected %h",
               {bus.mem_req, bus.mem_addr, bus.mem_be, bus.wb_valid}, {1'b1, 32'h10, 4'hF, 1'b0});
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    tests++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 3'd5, 32'hDEAD_BEEF}) begin
      failed++;
      $display("FAIL wload_wb: got %h expected %h", {bus.wb_valid, bus.wb_rd, bus.wb_data}, {1'b1, 3'd5, 32'hDEAD_BEEF});
    end
    tests++;
    if ({bus.mem_req, bus.req_ready} !== 2'b00) begin
      failed++;
      $display("FAIL wload_resp_state: got %b expected %b", {bus.mem_req, bus.req_ready}, 2'b00);
    end
    @(negedge clk);
    tests++;
    if ({bus.wb_valid, bus.req_ready, bus.busy, bus.wb_rd, bus.wb_data} !== {3'b010, 3'd5, 32'hDEAD_BEEF}) begin
      failed++;
      $display("FAIL wload_after: got %h expected %h",
               {bus.wb_valid, bus.req_ready, bus.busy, bus.wb_rd, bus.wb_data}, {3'b010, 3'd5, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_byte_store();
    present(1'b1, 1'b1, 3'd0, 32'h0000_0007, 32'h1234_56A5);
    @(negedge clk);
    bus.req_valid = 1'b0;
    tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be} !== {1'b1, 1'b1, 4'b1000}) begin
      failed++;
      $display("FAIL bstore_ctrl: got %b expected %b", {bus.mem_req, bus.mem_we, bus.mem_be}, {1'b1, 1'b1, 4'b1000});
    end
    tests++;
    if ({bus.mem_addr, bus.mem_wdata} !== {32'h4, 32'hA5A5_A5A5}) begin
      failed++;
      $display("FAIL bstore_data: got %h expected %h", {bus.mem_addr, bus.mem_wdata}, {32'h4, 32'hA5A5_A5A5});
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    tests++;
    if ({bus.req_ready, bus.mem_req, bus.wb_valid, bus.busy, bus.wb_data} !== {4'b1000, 32'hDEAD_BEEF}) begin
      failed++;
      $display("FAIL bstore_done: got %h expected %h",
               {bus.req_ready, bus.mem_req, bus.wb_valid, bus.busy, bus.wb_data}, {4'b1000, 32'hDEAD_BEEF});
    end
  endtask

  task automatic test_byte_load();
    present(1'b0, 1'b1, 3'd3, 32'h0000_0002, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'b0100, 32'h0}) begin
      failed++;
      $display("FAIL bload_issue: got %h expected %h",
               {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b1, 1'b0, 4'b0100, 32'h0});
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11C3_7788;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    tests++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 3'd3, 32'h0000_00C3}) begin
      failed++;
      $display("FAIL bload_wb: got %h expected %h", {bus.wb_valid, bus.wb_rd, bus.wb_data}, {1'b1, 3'd3, 32'h0000_00C3});
    end
    @(negedge clk);
    tests++;
    if ({bus.wb_valid, bus.req_ready} !== 2'b01) begin
      failed++;
      $display("FAIL bload_after: got %b expected %b", {bus.wb_valid, bus.req_ready}, 2'b01);
    end
  endtask

  task automatic test_misaligned();
    present(1'b0, 1'b0, 3'd2, 32'h0000_0006, 32'h0);
    @(negedge clk);
    tests++;
    if ({bus.mem_req, bus.busy, bus.err, bus.err_code, bus.req_ready} !== 6'b001011) begin
      failed++;
      $display("FAIL misalign_err: got %b expected %b",
               {bus.mem_req, bus.busy, bus.err, bus.err_code, bus.req_ready}, 6'b001011);
    end
    present(1'b1, 1'b0, 3'd0, 32'h0000_0020, 32'hCAFE_F00D);
    @(negedge clk);
    bus.req_valid = 1'b0;
    tests++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {1'b1, 32'h20, 32'hCAFE_F00D, 4'hF}) begin
      failed++;
      $display("FAIL back_to_back_accept: got %h expected %h",
               {bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_be}, {1'b1, 32'h20, 32'hCAFE_F00D, 4'hF});
    end
    tests++;
    if ({bus.err, bus.err_code} !== 3'b101) begin
      failed++;
      $display("FAIL err_sticky: got %b expected %b", {bus.err, bus.err_code}, 3'b101);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    tests++;
    if ({bus.req_ready, bus.mem_req} !== 2'b10) begin
      failed++;
      $display("FAIL back_to_back_done: got %b expected %b", {bus.req_ready, bus.mem_req}, 2'b10);
    end
  endtask

  task automatic test_timeout();
    int hi = 0;
    int wbs = 0;
    present(1'b0, 1'b0, 3'd1, 32'h0000_0040, 32'h0);
    for (int unsigned i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_req) hi++;
      if (bus.wb_valid) wbs++;
    end
    @(negedge clk);
    if (bus.wb_valid) wbs++;
    tests++;
    if ({bus.mem_req, bus.err, bus.err_code, bus.req_ready} !== 5'b01101) begin
      failed++;
      $display("FAIL timeout_err: got %b expected %b", {bus.mem_req, bus.err, bus.err_code, bus.req_ready}, 5'b01101);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_req) hi++;
      if (bus.wb_valid) wbs++;
    end
    tests++;
    if (hi !== 15) begin
      failed++;
      $display("FAIL timeout_req_cycles: got %0d expected %0d", hi, 15);
    end
    tests++;
    if (wbs !== 0) begin
      failed++;
      $display("FAIL timeout_no_wb: got %0d expected %0d", wbs, 0);
    end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    tests++;
    if ({bus.err, bus.err_code} !== 3'b000) begin
      failed++;
      $display("FAIL err_clr: got %b expected %b", {bus.err, bus.err_code}, 3'b000);
    end
  endtask

  task automatic test_reset_mid();
    present(1'b0, 1'b0, 3'd6, 32'h0000_0080, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    tests++;
    if (bus.mem_req !== 1'b1) begin
      failed++;
      $display("FAIL rstmid_issue: got %b expected %b", bus.mem_req, 1'b1);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({bus.mem_req, bus.busy, bus.req_ready} !== 3'b001) begin
      failed++;
      $display("FAIL rstmid_async: got %b expected %b", {bus.mem_req, bus.busy, bus.req_ready}, 3'b001);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    tests++;
    if ({bus.wb_valid, bus.mem_req, bus.busy, bus.req_ready, bus.wb_data} !== {4'b0001, 32'h0}) begin
      failed++;
      $display("FAIL rstmid_stray_ack: got %h expected %h",
               {bus.wb_valid, bus.mem_req, bus.busy, bus.req_ready, bus.wb_data}, {4'b0001, 32'h0});
    end
    present(1'b0, 1'b0, 3'd7, 32'h0000_0104, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    tests++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h104}) begin
      failed++;
      $display("FAIL rstmid_next_issue: got %h expected %h", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h104});
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    tests++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 3'd7, 32'h0BAD_F00D}) begin
      failed++;
      $display("FAIL rstmid_next_wb: got %h expected %h", {bus.wb_valid, bus.wb_rd, bus.wb_data}, {1'b1, 3'd7, 32'h0BAD_F00D});
    end
    @(negedge clk);
    tests++;
    if ({bus.wb_valid, bus.req_ready} !== 2'b01) begin
      failed++;
      $display("FAIL rstmid_next_done: got %b expected %b", {bus.wb_valid, bus.req_ready}, 2'b01);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_load();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
